// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit registers with byte strobes,
// SLVERR on out-of-range addresses, and independent read and write FSMs.
module axi_lite_reg_slave #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [DATA_W-1:0]          s_wdata,
  input  logic [DATA_W/8-1:0]        s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [ADDR_W-1:0]          s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-3:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic             aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             w_in_range, r_in_range;
  logic             unused_addr_bits;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // Byte offset bits play no part in decode.
  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign w_idx      = waddr_q[IDX_W-1:0];
  assign w_in_range = (waddr_q[ADDR_W-3:IDX_W] == '0);
  assign r_idx      = s_araddr[2 +: IDX_W];
  assign r_in_range = (s_araddr[ADDR_W-1:IDX_W+2] == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: next-state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_COMMIT;
        else if (aw_hs)    w_next = W_WAIT_W;
        else if (w_hs)     w_next = W_WAIT_AW;
      end
      W_WAIT_AW: if (aw_hs)    w_next = W_COMMIT;
      W_WAIT_W:  if (w_hs)     w_next = W_COMMIT;
      W_COMMIT:                w_next = W_RESP;
      W_RESP:    if (s_bready) w_next = W_IDLE;
      default:                 w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)    r_next = R_RESP;
      R_RESP:  if (s_rready) r_next = R_IDLE;
      default:               r_next = R_IDLE;
    endcase
  end

  // Handshake flops are driven from the next state, so they are glitch-free
  // registered outputs and first rise on the edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      s_awready <= (w_next == W_IDLE) || (w_next == W_WAIT_AW);
      s_wready  <= (w_next == W_IDLE) || (w_next == W_WAIT_W);
      s_bvalid  <= (w_next == W_RESP);
      if (w_state == W_COMMIT) s_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      s_arready <= (r_next == R_IDLE);
      s_rvalid  <= (r_next == R_RESP);
      if (ar_hs) begin
        s_rdata <= r_in_range ? regs[r_idx] : '0;
        s_rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) waddr_q <= s_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
    end
  end

  // NOTE: the register bank is reset because its contents are architecturally visible on regs_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (w_state == W_COMMIT && w_in_range) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
        if (|wstrb_q) wr_pulse_o[w_idx] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_export
    assign regs_o[DATA_W*k +: DATA_W] = regs[k];
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite responder (subordinate) with an internal bank of NUM_REGS 32-bit registers.
- Complements the existing initiator path: the bus master drives it directly, with no native RAM behind it.
- Used for control/status registers next to the RAM datapath; register contents are exported for downstream logic.
- Handles the five AXI4-Lite channels independently, with byte strobes and SLVERR on out-of-range addresses.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; power of 2, 2..256.
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; fixed at 32, with 4 strobe bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables; bit n covers bits [8n+7:8n].
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_W  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  32  read data.
- s_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- regs_o  out  NUM_REGS*32  flattened register contents; reg k at bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per register on a committed write.

Behaviour:
- Reset (async, active-high): all registers 0; all ready/valid outputs 0; s_bresp, s_rresp, s_rdata 0; wr_pulse_o 0.
- Ready outputs are registered. They first assert on the first rising edge after rst deasserts.
- Decode: index = addr[2 +: log2(NUM_REGS)]. addr[1:0] is ignored.
  - addr >= NUM_REGS*4 is out of range.
  - Out of range: SLVERR; a write does not modify any register; a read returns s_rdata 0.
- Write FSM states: W_IDLE, W_WAIT_AW, W_WAIT_W, W_COMMIT, W_RESP.
  - W_IDLE: s_awready=1 and s_wready=1.
    - Both handshake on the same edge: go to W_COMMIT.
    - AW only: latch the address, drop s_awready, go to W_WAIT_W.
    - W only: latch data and strobe, drop s_wready, go to W_WAIT_AW.
  - W_WAIT_AW / W_WAIT_W: wait for the missing channel's handshake, then go to W_COMMIT.
  - W_COMMIT (1 cycle, both readies 0):
    - Apply bytes where wstrb=1; set the wr_pulse_o bit (only if in range and wstrb != 0).
    - Drive s_bvalid=1 with s_bresp; go to W_RESP.
  - W_RESP: hold s_bvalid/s_bresp stable until s_bready. On handshake, clear s_bvalid, reassert both readies, go to W_IDLE.
  - Minimum AW+W handshake to s_bvalid: 2 cycles. Throughput: one write per 3 cycles when s_bready is held high.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: s_arready=1. On handshake, register s_rdata/s_rresp from the current register value, set s_rvalid next cycle (latency 1), drop s_arready.
  - R_RESP: hold s_rdata, s_rresp and s_rvalid stable until s_rready. Then return to R_IDLE with s_arready=1.
- The read and write FSMs are fully independent. A read and a write may be in flight at once.
- Collision: an AR handshake on the same edge as a W_COMMIT to the same register returns the pre-write value.
- Valid outputs never drop without the matching ready handshake.
- Reset mid-transaction aborts it immediately. Pending responses are discarded; registers clear.

Test Plan:
- Reset, then AW+W on the same cycle: addr 0x4, data 0xDEADBEEF, strb 0xF -> s_bvalid 2 cycles later, bresp 00, regs_o[63:32]=0xDEADBEEF, wr_pulse_o=0b10.
- W first, AW 3 cycles later: addr 0x8, data 0x11223344, strb 0x5 over prior 0xFFFFFFFF -> reg2=0xFF22FF44, bresp 00; s_wready low while waiting.
- Read addr 0x4 after test 1 -> s_rvalid 1 cycle after the AR handshake, s_rdata 0xDEADBEEF, rresp 00. Hold s_rready=0 for 4 cycles -> s_rdata and s_rvalid stay stable.
- Out of range, NUM_REGS=8: write 0x20 -> bresp 10, no reg change, no pulse. Read 0x24 -> rresp 10, rdata 0.
- Concurrent: write 0x0=0xA5A5A5A5 while reading 0x0 (old value 0x1), with AR on the commit edge -> rdata 0x00000001; the next read returns 0xA5A5A5A5.
- Assert rst while s_bvalid=1 and s_rvalid=1 -> all outputs 0 immediately, regs_o 0; the first transaction after release completes normally.
